// File: rtl/mul_seq_unit.sv
// Iterative shift-add multiplier for the EX stage.
// Produces a 2*WIDTH-bit product over WIDTH clock cycles. The low word feeds
// the ALU-result select mux, the high word feeds the HI register path.
//
// Handshake: start_i is accepted only when the unit is IDLE or DONE (and
// kill_i is low). Operands and signed_i are captured on the accepting edge;
// they may change freely afterwards. busy_o is high for the WIDTH cycles of
// iteration, and done_o pulses for exactly one cycle when prod_lo_o/prod_hi_o
// carry the new product. The product outputs hold until the next DONE or a
// reset. kill_i aborts any operation without a done_o pulse.
module mul_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             kill_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_lo_o,
  output logic [WIDTH-1:0] prod_hi_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic                 load;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 neg_q;
  logic [WIDTH-1:0]     prod_lo_q, prod_hi_q;

  logic [WIDTH-1:0]     mag1, mag2;
  logic                 neg_in;
  logic [2*WIDTH-1:0]   acc_add;
  logic [2*WIDTH-1:0]   product;

  // Operand magnitudes and result sign; the most negative value maps to
  // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
  always_comb begin
    mag1    = (signed_i && src1_i[WIDTH-1]) ? -src1_i : src1_i;
    mag2    = (signed_i && src2_i[WIDTH-1]) ? -src2_i : src2_i;
    neg_in  = signed_i & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
    acc_add = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    product = neg_q ? -acc_add : acc_add;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and operand-load decision; kill_i overrides all moves.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        if (start_i) begin
          state_d = RUN;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (kill_i) begin
      state_d = IDLE;
      load    = 1'b0;
    end
  end

  // Datapath: operand capture, one shift-add step per RUN cycle, and product
  // registration on the final step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
    end else if (load) begin
      cnt_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, mag1};
      mplier_q <= mag2;
      acc_q    <= '0;
      neg_q    <= neg_in;
    end else if (state_q == RUN && !kill_i) begin
      acc_q    <= acc_add;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        prod_lo_q <= product[WIDTH-1:0];
        prod_hi_q <= product[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == DONE);
  assign prod_lo_o   = prod_lo_q;
  assign prod_hi_o   = prod_hi_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Self-checking bench for mul_seq_unit: directed corner cases plus randomized
// multiplies, checked against a plain 64-bit arithmetic reference.
module tb_mul_seq_unit;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         signed_i;
  logic [W-1:0] src1_i;
  logic [W-1:0] src2_i;
  logic         kill_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] prod_lo_o;
  logic [W-1:0] prod_hi_o;
  logic [1:0]   dbg_state_o;

  int checks   = 0;
  int failures = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_prod;

  mul_seq_unit #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .kill_i      (kill_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .prod_lo_o   (prod_lo_o),
    .prod_hi_o   (prod_hi_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock.
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [2*W-1:0] got,
                       input logic [2*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: extend each operand to 2*W bits and multiply modulo 2^(2*W).
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic s);
    logic [2*W-1:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Drive a one-cycle start; returns one negedge after the sampling edge.
  task automatic start_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s);
    start_i  = 1'b1;
    src1_i   = a;
    src2_i   = b;
    signed_i = s;
    exp_q.push_back(ref_mul(a, b, s));
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Wait for done_o (bounded), checking busy span, exclusivity and that the
  // previous product is held; optional noise pokes start/operands while busy.
  task automatic wait_done(input string tag, input bit noise);
    int n;
    int busy_cnt;
    n = 1;
    busy_cnt = 0;
    while (!done_o && n < 100) begin
      if (busy_o) busy_cnt++;
      check({tag, "_hold"}, {prod_hi_o, prod_lo_o}, last_prod);
      if (noise && busy_o) begin
        start_i  = 1'($urandom_range(0, 1));
        src1_i   = $urandom;
        src2_i   = $urandom;
        signed_i = 1'($urandom_range(0, 1));
      end
      @(negedge clk_i);
      n++;
    end
    start_i = 1'b0;
    check({tag, "_done"}, 64'(done_o), 64'd1);
    check({tag, "_lat"}, 64'(n), 64'd33);
    check({tag, "_busycnt"}, 64'(busy_cnt), 64'd32);
    check({tag, "_excl"}, 64'(busy_o & done_o), 64'd0);
    if (exp_q.size() > 0) begin
      last_prod = exp_q.pop_front();
      check({tag, "_prod"}, {prod_hi_o, prod_lo_o}, last_prod);
    end else begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s);
    start_mul(a, b, s);
    wait_done(tag, 1'b0);
    @(negedge clk_i);
    check({tag, "_pulse"}, 64'(done_o), 64'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    last_prod = '0;
    exp_q.delete();
  endtask

  initial begin
    int dones;
    logic [W-1:0] ra, rb;
    rst_i = 1'b1; start_i = 1'b0; signed_i = 1'b0;
    src1_i = '0; src2_i = '0; kill_i = 1'b0;
    last_prod = '0;
    @(negedge clk_i);
    do_reset();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_prod", {prod_hi_o, prod_lo_o}, 64'd0);

    // Directed products.
    run_one("u7x6", 32'd7, 32'd6, 1'b0);
    check("u7x6_val", {prod_hi_o, prod_lo_o}, 64'd42);
    run_one("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1);
    check("s_m3x5_val", {prod_hi_o, prod_lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_one("u_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b0);
    check("u_m3x5_val", {prod_hi_o, prod_lo_o}, 64'h0000_0004_FFFF_FFF1);
    run_one("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("u_max_val", {prod_hi_o, prod_lo_o}, 64'hFFFF_FFFE_0000_0001);
    run_one("s_min", 32'h8000_0000, 32'h8000_0000, 1'b1);
    check("s_min_val", {prod_hi_o, prod_lo_o}, 64'h4000_0000_0000_0000);
    run_one("zero", 32'd0, 32'h1234_5678, 1'b1);

    // Back-to-back: new start in the DONE cycle.
    start_mul(32'd9, 32'd11, 1'b0);
    wait_done("b2b1", 1'b0);
    start_mul(32'd2, 32'd3, 1'b0);
    wait_done("b2b2", 1'b0);
    check("b2b2_val", {prod_hi_o, prod_lo_o}, 64'd6);
    @(negedge clk_i);

    // Start ignored while running, operands scrambled.
    start_mul(32'hDEAD_BEEF, 32'hFFFF_FF00, 1'b1);
    wait_done("noise", 1'b1);
    @(negedge clk_i);

    // Kill at RUN cycle 10: no done, product unchanged.
    start_mul(32'd100, 32'd200, 1'b0);
    void'(exp_q.pop_back());
    repeat (9) @(negedge clk_i);
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    check("kill_busy", 64'(busy_o), 64'd0);
    dones = 0;
    repeat (40) begin
      if (done_o) dones++;
      @(negedge clk_i);
    end
    check("kill_nodone", 64'(dones), 64'd0);
    check("kill_prod", {prod_hi_o, prod_lo_o}, last_prod);

    // Kill and start together: start dropped.
    start_i = 1'b1; kill_i = 1'b1; src1_i = 32'd5; src2_i = 32'd5;
    @(negedge clk_i);
    start_i = 1'b0; kill_i = 1'b0;
    check("killstart_busy", 64'(busy_o), 64'd0);

    // Reset mid-run clears everything, no done afterwards.
    start_mul(32'd123, 32'd456, 1'b0);
    repeat (5) @(negedge clk_i);
    check("midrun_busy", 64'(busy_o), 64'd1);
    do_reset();
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_prod", {prod_hi_o, prod_lo_o}, 64'd0);
    dones = 0;
    repeat (40) begin
      if (done_o) dones++;
      @(negedge clk_i);
    end
    check("midrst_nodone", 64'(dones), 64'd0);

    // Randomized operands with occasional corner values.
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      run_one($sformatf("rnd%0d", i), ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
